// File: rtl/counter_ctrl.sv
// Run/pause/step/done controller for a two-digit BCD counter with prescaler,
// driving an active-low two-digit seven-segment bus (tens blanked when zero).
module counter_ctrl #(
  parameter int unsigned DIV = 4,
  parameter int unsigned MAX = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        mode,
  output logic [13:0] seg,
  output logic        running,
  output logic        done
);

  localparam int unsigned PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0]  MAX_T  = 4'(MAX / 10);
  localparam logic [3:0]  MAX_U  = 4'(MAX % 10);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [6:0]  BLANK  = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [3:0]    tens_q, tens_d, units_q, units_d;
  logic [PW-1:0] p_q, p_d;

  logic       tick;
  logic       at_max;
  logic [3:0] inc_tens, inc_units;
  logic       inc_hits_max;
  logic       do_inc;

  // Next count value for one increment, including the terminal behaviour
  always_comb begin
    at_max    = (tens_q == MAX_T) && (units_q == MAX_U);
    inc_tens  = tens_q;
    inc_units = units_q;
    if (at_max) begin
      if (!mode) begin
        inc_tens  = 4'd0;
        inc_units = 4'd0;
      end
    end else if (units_q == 4'd9) begin
      inc_units = 4'd0;
      inc_tens  = tens_q + 4'd1;
    end else begin
      inc_units = units_q + 4'd1;
    end
    inc_hits_max = (inc_tens == MAX_T) && (inc_units == MAX_U);
  end

  assign tick = (p_q == P_LAST);

  // Next-state: priority clr > stop > start > step; p only advances in RUN
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    p_d     = '0;
    do_inc  = 1'b0;

    if (clr) begin
      state_d = S_IDLE;
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (start) begin
            state_d = S_RUN;
          end else if (step) begin
            do_inc = 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            do_inc = 1'b1;
          end else begin
            p_d = p_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state_d = S_PAUSE;
          end else if (start) begin
            state_d = S_RUN;
          end else if (step) begin
            do_inc = 1'b1;
          end
        end
        S_DONE: begin
          if (!stop && start) begin
            state_d = S_RUN;
            tens_d  = 4'd0;
            units_d = 4'd0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (do_inc) begin
        tens_d  = inc_tens;
        units_d = inc_units;
        if (mode && inc_hits_max) begin
          state_d = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      p_q     <= p_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction

  assign seg     = {seg7(units_q), (tens_q == 4'd0) ? BLANK : seg7(tens_q)};
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: three instances with different DIV/MAX
// share stimulus; each scenario checks the instance it targets.
module tb_counter_ctrl;

  logic clk = 1'b0;
  logic rst, clr, start, stop, step, mode;
  logic [13:0] seg_a, seg_b, seg_c;
  logic run_a, run_b, run_c, done_a, done_b, done_c;

  int n_run  = 0;
  int n_fail = 0;
  logic [13:0] exp_q[$];
  logic [13:0] exp;

  localparam logic [13:0] RST_SEG = 14'b10000001111111;

  always #5 clk = ~clk;

  counter_ctrl #(.DIV(4), .MAX(99)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .stop(stop), .step(step),
    .mode(mode), .seg(seg_a), .running(run_a), .done(done_a));
  counter_ctrl #(.DIV(1), .MAX(99)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .stop(stop), .step(step),
    .mode(mode), .seg(seg_b), .running(run_b), .done(done_b));
  counter_ctrl #(.DIV(2), .MAX(3)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .stop(stop), .step(step),
    .mode(mode), .seg(seg_c), .running(run_c), .done(done_c));

  function automatic logic [6:0] digit(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [13:0] seg_of(input int v);
    logic [6:0] t;
    t = (v / 10 == 0) ? 7'b1111111 : digit(v / 10);
    return {digit(v % 10), t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(RST_SEG);
      tick();
      exp = exp_q.pop_front();
      n_run++;
      if (seg_a !== exp || run_a !== 1'b0 || done_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: seg=%b run=%b done=%b, want seg=%b run=0 done=0",
                 i, seg_a, run_a, done_a, exp);
      end
    end
  endtask

  task automatic test_run_div4();
    do_reset();
    mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n_run++;
    if (run_a !== 1'b1) begin
      n_fail++; $display("FAIL div4_running: got %b want 1", run_a);
    end
    for (int v = 1; v <= 3; v++) exp_q.push_back(seg_of(v));
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i % 4 == 0) begin
        exp = exp_q.pop_front();
        n_run++;
        if (seg_a !== exp) begin
          n_fail++; $display("FAIL div4_count edge%0d: got %b want %b", i, seg_a, exp);
        end
      end
    end
    stop = 1'b1; tick(); stop = 1'b0;
    n_run++;
    if (run_a !== 1'b0) begin
      n_fail++; $display("FAIL div4_stop_running: got %b want 0", run_a);
    end
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(seg_of(3));
      tick();
      exp = exp_q.pop_front();
      n_run++;
      if (seg_a !== exp) begin
        n_fail++; $display("FAIL div4_hold cyc%0d: got %b want %b", i, seg_a, exp);
      end
    end
  endtask

  task automatic test_run_div1_wrap();
    do_reset();
    mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      exp_q.push_back(seg_of(k % 100));
      tick();
      exp = exp_q.pop_front();
      n_run++;
      if (seg_b !== exp || done_b !== 1'b0) begin
        n_fail++;
        $display("FAIL div1_count edge%0d: seg=%b done=%b, want seg=%b done=0", k, seg_b, done_b, exp);
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_q.push_back(seg_of(k / 2));
      tick();
      exp = exp_q.pop_front();
      n_run++;
      if (seg_c !== exp || done_c !== (k == 6)) begin
        n_fail++;
        $display("FAIL oneshot edge%0d: seg=%b done=%b, want seg=%b done=%0d", k, seg_c, done_c, exp, (k == 6));
      end
    end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(14'b01100001111111);
      tick();
      exp = exp_q.pop_front();
      n_run++;
      if (seg_c !== exp || done_c !== 1'b1) begin
        n_fail++;
        $display("FAIL oneshot_hold cyc%0d: seg=%b done=%b, want seg=%b done=1", i, seg_c, done_c, exp);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    n_run++;
    if (seg_c !== RST_SEG || run_c !== 1'b1 || done_c !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_restart: seg=%b run=%b done=%b, want seg=%b run=1 done=0", seg_c, run_c, done_c, RST_SEG);
    end
    mode = 1'b0;
  endtask

  task automatic test_pause();
    do_reset();
    mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    n_run++;
    if (run_a !== 1'b0 || seg_a !== seg_of(1)) begin
      n_fail++; $display("FAIL pause_entry: run=%b seg=%b, want run=0 seg=%b", run_a, seg_a, seg_of(1));
    end
    for (int i = 1; i <= 3; i++) begin
      step = 1'b1;
      exp_q.push_back(seg_of(1 + i));
      tick();
      step = 1'b0;
      exp = exp_q.pop_front();
      n_run++;
      if (seg_a !== exp) begin
        n_fail++; $display("FAIL pause_step%0d: got %b want %b", i, seg_a, exp);
      end
      tick();
    end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    n_run++;
    if (run_a !== 1'b0 || seg_a !== seg_of(4)) begin
      n_fail++; $display("FAIL pause_start_stop: run=%b seg=%b, want run=0 seg=%b", run_a, seg_a, seg_of(4));
    end
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; tick(); step = 1'b0;
    exp_q.push_back(seg_of(4));
    exp_q.push_back(seg_of(5));
    tick(); tick();
    exp = exp_q.pop_front();
    n_run++;
    if (seg_a !== exp || run_a !== 1'b1) begin
      n_fail++; $display("FAIL run_step_ignored: seg=%b run=%b, want seg=%b run=1", seg_a, run_a, exp);
    end
    tick();
    exp = exp_q.pop_front();
    n_run++;
    if (seg_a !== exp) begin
      n_fail++; $display("FAIL run_after_step: got %b want %b", seg_a, exp);
    end
  endtask

  task automatic test_clr();
    do_reset();
    mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    n_run++;
    if (seg_b !== seg_of(7)) begin
      n_fail++; $display("FAIL clr_pre: got %b want %b", seg_b, seg_of(7));
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_run++;
    if (seg_b !== RST_SEG || run_b !== 1'b0) begin
      n_fail++; $display("FAIL clr_run: seg=%b run=%b, want seg=%b run=0", seg_b, run_b, RST_SEG);
    end
    tick(); tick();
    n_run++;
    if (seg_b !== RST_SEG || run_b !== 1'b0) begin
      n_fail++; $display("FAIL clr_idle: seg=%b run=%b, want seg=%b run=0", seg_b, run_b, RST_SEG);
    end
  endtask

  task automatic test_rst_with_start();
    do_reset();
    mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    n_run++;
    if (seg_a !== RST_SEG || run_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start: seg=%b run=%b done=%b, want seg=%b run=0 done=0", seg_a, run_a, done_a, RST_SEG);
    end
    tick();
    n_run++;
    if (run_a !== 1'b0) begin
      n_fail++; $display("FAIL rst_start_idle: run=%b want 0", run_a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; mode = 1'b0;
    test_reset();
    test_run_div4();
    test_run_div1_wrap();
    test_oneshot();
    test_pause();
    test_clr();
    test_rst_with_start();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
